conv_stream_ctrl: RTL and testbench

// Frame-level sequencer for the streaming Conv datapath. Per start command it optionally loads

---
 rtl/conv_stream_ctrl.sv | 154 +++++++++++++++
 tb/tb_conv_stream_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_stream_ctrl.sv
// Frame sequencer for the streaming Conv datapath: serial weight load, Conv clear,
// pixel gating into Conv, result capture into a FWFT FIFO, and done/timeout reporting.
module conv_stream_ctrl #(
  parameter int Kernal_Dim = 2,
  parameter int Kernal_Ch  = 3,
  parameter int Img_Dim    = 4,
  parameter int Img_Ch     = 3,
  parameter int Out_Dim    = 2,
  parameter int DRAIN_TMO  = 64
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    reload_w,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    err_tmo,
  input  logic [7:0]                              wt_data,
  input  logic                                    wt_valid,
  output logic                                    wt_ready,
  output logic [Kernal_Dim*Kernal_Dim*Kernal_Ch*8-1:0] wt_flat,
  input  logic [7:0]                              pix_data,
  input  logic                                    pix_valid,
  output logic                                    pix_ready,
  output logic                                    conv_clr,
  output logic [7:0]                              conv_pix,
  output logic                                    conv_valid,
  input  logic [15:0]                             conv_out,
  input  logic                                    conv_out_vld,
  output logic [15:0]                             res_data,
  output logic                                    res_valid,
  input  logic                                    res_ready
);

  localparam int N_W   = Kernal_Dim * Kernal_Dim * Kernal_Ch;
  localparam int N_PIX = Img_Dim * Img_Dim * Img_Ch;
  localparam int N_OUT = Out_Dim * Out_Dim;
  localparam int WCW   = $clog2(N_W + 1);
  localparam int PCW   = $clog2(N_PIX + 1);
  localparam int OCW   = $clog2(N_OUT + 1);
  localparam int TCW   = $clog2(DRAIN_TMO + 1);
  localparam int FAW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_CLEAR, S_STREAM, S_DRAIN, S_DONE
  } state_t;

  state_t         state;
  logic [WCW-1:0] wcnt;
  logic [PCW-1:0] pcnt;
  logic [OCW-1:0] ocnt;
  logic [TCW-1:0] tmo;

  logic [15:0]    fifo_mem [N_OUT];
  logic [FAW-1:0] wr_ptr, rd_ptr;
  logic [OCW-1:0] fifo_cnt;
  logic           fifo_empty, push, pop;

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign wt_ready  = (state == S_LOAD_W);
  assign pix_ready = (state == S_STREAM);
  assign conv_clr  = (state == S_CLEAR);

  // Results only count while a frame is streaming/draining; extras past N_OUT are dropped.
  assign push       = (state == S_STREAM || state == S_DRAIN) && conv_out_vld &&
                      (ocnt < OCW'(N_OUT));
  assign pop        = res_valid && res_ready;
  assign fifo_empty = (fifo_cnt == '0);
  assign res_valid  = !fifo_empty;
  assign res_data   = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      pcnt       <= '0;
      ocnt       <= '0;
      tmo        <= '0;
      err_tmo    <= 1'b0;
      wt_flat    <= '0;
      conv_pix   <= '0;
      conv_valid <= 1'b0;
    end else begin
      // NOTE: defaults first, later non-blocking assignments in the case override them.
      conv_valid <= 1'b0;
      if (push) ocnt <= ocnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (start && fifo_empty) begin
            err_tmo <= 1'b0;
            wcnt    <= '0;
            state   <= reload_w ? S_LOAD_W : S_CLEAR;
          end
        end
        S_LOAD_W: begin
          if (wt_valid) begin
            wt_flat[8*int'(wcnt) +: 8] <= wt_data;
            wcnt <= wcnt + 1'b1;
            if (wcnt == WCW'(N_W - 1)) state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          pcnt  <= '0;
          ocnt  <= '0;
          tmo   <= '0;
          state <= S_STREAM;
        end
        S_STREAM: begin
          if (pix_valid) begin
            conv_pix   <= pix_data;
            conv_valid <= 1'b1;
            pcnt       <= pcnt + 1'b1;
            if (pcnt == PCW'(N_PIX - 1)) state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          tmo <= tmo + 1'b1;
          if (ocnt == OCW'(N_OUT)) begin
            state <= S_DONE;
          end else if (tmo == TCW'(DRAIN_TMO - 1)) begin
            err_tmo <= 1'b1;
            state   <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  function automatic logic [FAW-1:0] ptr_inc(input logic [FAW-1:0] p);
    return (p == FAW'(N_OUT - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage has no reset; validity is carried entirely by fifo_cnt.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= conv_out;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_stream_ctrl.sv
// Randomized bench for conv_stream_ctrl: a frame-level reference model checked every
// cycle, a stand-in Conv that emits results, and literal checks for the frame scenarios.
module tb_conv_stream_ctrl;

  localparam int KD = 2, KC = 3, ID = 4, IC = 3, OD = 2, TMO = 64;
  localparam int NW = KD*KD*KC, NP = ID*ID*IC, NO = OD*OD;

  logic          clk = 1'b0, rst = 1'b0;
  logic          start = 0, reload_w = 0, busy, done, err_tmo;
  logic [7:0]    wt_data = '0;
  logic          wt_valid = 0, wt_ready;
  logic [NW*8-1:0] wt_flat;
  logic [7:0]    pix_data = '0;
  logic          pix_valid = 0, pix_ready, conv_clr, conv_valid;
  logic [7:0]    conv_pix;
  logic [15:0]   conv_out = '0;
  logic          conv_out_vld = 0;
  logic [15:0]   res_data;
  logic          res_valid, res_ready = 0;

  always #5 clk = ~clk;

  conv_stream_ctrl #(
    .Kernal_Dim(KD), .Kernal_Ch(KC), .Img_Dim(ID), .Img_Ch(IC), .Out_Dim(OD), .DRAIN_TMO(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .reload_w(reload_w), .busy(busy), .done(done),
    .err_tmo(err_tmo), .wt_data(wt_data), .wt_valid(wt_valid), .wt_ready(wt_ready),
    .wt_flat(wt_flat), .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .conv_clr(conv_clr), .conv_pix(conv_pix), .conv_valid(conv_valid), .conv_out(conv_out),
    .conv_out_vld(conv_out_vld), .res_data(res_data), .res_valid(res_valid),
    .res_ready(res_ready)
  );

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: dut=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame phases, plain counters, queue FIFO) ----------
  typedef enum {M_IDLE, M_LOAD, M_CLEAR, M_STREAM, M_DRAIN, M_DONE} mphase_t;
  mphase_t     ph = M_IDLE;
  int          n_w = 0, n_pix = 0, n_out = 0, n_drain = 0;
  bit          m_err = 0, m_cv = 0;
  logic [7:0]  m_cp = '0;
  logic [NW*8-1:0] m_flat = '0;
  logic [15:0] m_fifo[$];

  always @(posedge clk) begin : ref_model
    bit      was_empty;
    mphase_t nxt;
    if (!rst) begin
      ph = M_IDLE; m_err = 0; m_cv = 0; m_cp = '0; m_flat = '0; m_fifo.delete();
      n_w = 0; n_pix = 0; n_out = 0; n_drain = 0;
    end else begin
      was_empty = (m_fifo.size() == 0);
      nxt  = ph;
      m_cv = 0;
      case (ph)
        M_IDLE:   if (start && was_empty) begin
                    m_err = 0; n_w = 0; nxt = reload_w ? M_LOAD : M_CLEAR;
                  end
        M_LOAD:   if (wt_valid) begin
                    m_flat[8*n_w +: 8] = wt_data; n_w++;
                    if (n_w == NW) nxt = M_CLEAR;
                  end
        M_CLEAR:  begin n_pix = 0; n_out = 0; n_drain = 0; nxt = M_STREAM; end
        M_STREAM: if (pix_valid) begin
                    m_cv = 1; m_cp = pix_data; n_pix++;
                    if (n_pix == NP) nxt = M_DRAIN;
                  end
        M_DRAIN:  begin
                    if (n_out == NO) nxt = M_DONE;
                    else if (n_drain == TMO-1) begin m_err = 1; nxt = M_DONE; end
                    n_drain++;
                  end
        default:  nxt = M_IDLE;
      endcase
      if (!was_empty && res_ready) void'(m_fifo.pop_front());
      if ((ph == M_STREAM || ph == M_DRAIN) && conv_out_vld && n_out < NO) begin
        m_fifo.push_back(conv_out);
        n_out++;
      end
      ph = nxt;
    end
  end

  always @(posedge clk) begin : compare
    #1;
    check("busy",       busy,       ph != M_IDLE);
    check("done",       done,       ph == M_DONE);
    check("wt_ready",   wt_ready,   ph == M_LOAD);
    check("pix_ready",  pix_ready,  ph == M_STREAM);
    check("conv_clr",   conv_clr,   ph == M_CLEAR);
    check("err_tmo",    err_tmo,    m_err);
    check("conv_valid", conv_valid, m_cv);
    check("conv_pix",   conv_pix,   m_cp);
    check("wt_flat",    wt_flat,    m_flat);
    check("res_valid",  res_valid,  m_fifo.size() != 0);
    if (m_fifo.size() != 0) check("res_data", res_data, m_fifo[0]);
  end

  // ---------------- stand-in Conv: one result per NP/NO accepted pixels -----------------
  int          cv_seen = 0, emitted = 0, emit_n = NO;
  bit          extra_en = 0, noise_en = 0;
  logic [15:0] conv_emitted[$];

  always @(negedge clk) begin : conv_model
    conv_out_vld = 1'b0;
    if (!rst || conv_clr) begin
      cv_seen = 0; emitted = 0; conv_emitted.delete();
    end else if (conv_valid) begin
      cv_seen++;
      if ((cv_seen % (NP/NO) == 0 || (extra_en && cv_seen == 6)) && emitted < emit_n) begin
        conv_out = 16'($urandom); conv_out_vld = 1'b1; emitted++;
        conv_emitted.push_back(conv_out);
      end
    end else if (noise_en && !busy && $urandom_range(0, 3) == 0) begin
      conv_out = 16'($urandom); conv_out_vld = 1'b1;
    end
  end

  // Cycles spent draining in the most recent frame.
  int drain_cnt = 0;
  always @(posedge clk) begin : drain_mon
    #2;
    if (!rst || pix_ready) drain_cnt = 0;
    else if (busy && !done && !wt_ready && !conv_clr) drain_cnt++;
  end

  // ---------------- stimulus helpers (inputs change on the falling edge) ----------------
  bit rr_rand = 0;
  int rd_idx  = 0;

  function automatic void upd_rr();
    res_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
  endfunction

  task automatic pulse_start(input bit rw);
    start = 1'b1; reload_w = rw;
    @(negedge clk);
    start = 1'b0; reload_w = 1'b0;
  endtask

  task automatic load_weights(input bit rnd, input int gap_pct);
    int n = 0, budget = 400;
    bit acc;
    while (n < NW && budget > 0) begin
      upd_rr();
      wt_valid = ($urandom_range(0, 99) >= gap_pct);
      wt_data  = rnd ? 8'($urandom) : 8'(n);
      acc = wt_valid && wt_ready;
      @(negedge clk);
      if (acc) n++;
      budget--;
    end
    wt_valid = 1'b0;
    check("wt_accepted", n, NW);
  endtask

  task automatic drive_pixels(input int num, input int pct, input bit rnd);
    int n = 0, budget = 20*num + 50;
    bit acc;
    while (n < num && budget > 0) begin
      upd_rr();
      pix_valid = ($urandom_range(0, 99) < pct);
      pix_data  = rnd ? 8'($urandom) : 8'(n);
      acc = pix_valid && pix_ready;
      @(negedge clk);
      if (acc) n++;
      budget--;
    end
    pix_valid = 1'b0;
    check("pix_accepted", n, num);
  endtask

  task automatic wait_done();
    int budget = 300;
    while (!done && budget > 0) begin
      upd_rr();
      @(negedge clk);
      budget--;
    end
    check("done_reached", done, 1'b1);
  endtask

  task automatic pop_results(input int max, input bit cmp, output int n);
    n = 0;
    res_ready = 1'b1;
    while (res_valid && n < max) begin
      if (cmp && rd_idx < conv_emitted.size()) check("res_vs_conv", res_data, conv_emitted[rd_idx]);
      rd_idx++;
      @(negedge clk);
      n++;
    end
    res_ready = 1'b0;
  endtask

  initial begin : main
    int n;
    logic [NW*8-1:0] w_t2;
    w_t2 = 96'h0b0a0908_0706050403020100;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_wt_flat", wt_flat, '0);
    check("rst_res_valid", res_valid, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // Weights 0..11, then a contiguous 48-pixel frame with results held in the FIFO.
    rd_idx = 0;
    pulse_start(1'b1);
    check("t2_wt_ready", wt_ready, 1'b1);
    load_weights(1'b0, 30);
    check("t2_wt_flat", wt_flat, w_t2);
    check("t2_clr_on", conv_clr, 1'b1);
    @(negedge clk);
    check("t2_clr_off", conv_clr, 1'b0);
    check("t3_pix_ready", pix_ready, 1'b1);
    drive_pixels(NP, 100, 1'b0);
    wait_done();
    check("t3_drain_cycles", drain_cnt, 2);
    pop_results(8, 1'b1, n);
    check("t3_results", n, NO);

    // Backpressure: results wait in the FIFO and block the next start.
    noise_en = 1;
    rd_idx = 0;
    pulse_start(1'b0);
    drive_pixels(NP, 50, 1'b1);
    wait_done();
    @(negedge clk);
    pop_results(3, 1'b1, n);
    check("t4_partial_pop", n, 3);
    check("t4_still_valid", res_valid, 1'b1);
    pulse_start(1'b1);
    check("t4_start_ignored", busy, 1'b0);
    pop_results(8, 1'b1, n);
    check("t4_last_pop", n, 1);
    check("t4_empty", res_valid, 1'b0);

    // Timeout: only three results arrive.
    emit_n = 3;
    rd_idx = 0;
    pulse_start(1'b0);
    drive_pixels(NP, 100, 1'b1);
    wait_done();
    check("t5_drain_cycles", drain_cnt, TMO);
    check("t5_err", err_tmo, 1'b1);
    @(negedge clk);
    check("t5_err_sticky", err_tmo, 1'b1);
    pop_results(8, 1'b1, n);
    check("t5_results", n, 3);

    // Reuse weights; an early extra result makes the frame's last one overflow and drop.
    emit_n = 5; extra_en = 1;
    rd_idx = 0;
    pulse_start(1'b0);
    check("t6_direct_clr", conv_clr, 1'b1);
    check("t6_err_cleared", err_tmo, 1'b0);
    check("t6_wt_kept", wt_flat, w_t2);
    drive_pixels(NP, 70, 1'b1);
    wait_done();
    check("t6_drain_cycles", drain_cnt, 1);
    pop_results(8, 1'b1, n);
    check("t6_results", n, NO);
    check("t6_dropped", conv_emitted.size() - rd_idx, 1);
    emit_n = NO; extra_en = 0;

    // Reset in the middle of streaming.
    pulse_start(1'b0);
    drive_pixels(20, 100, 1'b1);
    rst = 1'b0;
    #1;
    check("t1_busy", busy, 1'b0);
    check("t1_pix_ready", pix_ready, 1'b0);
    check("t1_conv_valid", conv_valid, 1'b0);
    check("t1_res_valid", res_valid, 1'b0);
    check("t1_wt_flat", wt_flat, '0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Random frame with fresh weights, random result backpressure and idle noise.
    rr_rand = 1;
    pulse_start(1'b1);
    load_weights(1'b1, 40);
    drive_pixels(NP, 60, 1'b1);
    wait_done();
    rr_rand = 0;
    pop_results(8, 1'b0, n);
    check("t7_empty", res_valid, 1'b0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
